// File: rtl/obstacle_tracker_pkg.sv
// Shared definitions for the obstacle tracker, sequencer and sprite renderer:
// lane encoding and the per-object track state.
package obstacle_tracker_pkg;

  localparam logic [1:0] LANE_NULL  = 2'b00;
  localparam logic [1:0] LANE_LEFT  = 2'b01;
  localparam logic [1:0] LANE_MID   = 2'b10;
  localparam logic [1:0] LANE_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    TRK_IDLE    = 2'd0,
    TRK_FALL    = 2'd1,
    TRK_RETIRED = 2'd2
  } trk_state_e;

endpackage

// File: rtl/obstacle_tracker_object_track.sv
// One falling object: spawn/fall/retire FSM, y position, stored lane and
// the penguin collision compare. Advances only when i_step is high.
module object_track
  import obstacle_tracker_pkg::*;
#(
  parameter logic [9:0] TOP_Y       = 10'd40,
  parameter logic [9:0] BOTTOM_Y    = 10'd470,
  parameter logic [9:0] PENG_Y_TOP  = 10'd380,
  parameter logic [9:0] PENG_Y_BOT  = 10'd440,
  parameter logic [3:0] SCROLL_STEP = 4'd4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_step,
  input  logic [1:0] i_release,
  input  logic [1:0] i_penguin_lane,
  input  logic       i_hit_mask,
  output logic       o_active,
  output logic [9:0] o_y,
  output logic       o_hit
);

  trk_state_e  state_q, state_d;
  logic [9:0]  y_q, y_d;
  logic [1:0]  lane_q, lane_d;
  logic [10:0] y_sum;
  logic        in_band;

  assign y_sum = {1'b0, y_q} + {7'b0, SCROLL_STEP};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= TRK_IDLE;
      y_q     <= TOP_Y;
      lane_q  <= LANE_NULL;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      lane_q  <= lane_d;
    end
  end

  // Lane changes take priority over a hit so a new release always respawns.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    lane_d  = lane_q;
    if (i_step) begin
      if (i_release == LANE_NULL) begin
        state_d = TRK_IDLE;
        lane_d  = LANE_NULL;
        y_d     = TOP_Y;
      end else if (i_release != lane_q) begin
        state_d = TRK_FALL;
        lane_d  = i_release;
        y_d     = TOP_Y;
      end else if (o_hit) begin
        state_d = TRK_RETIRED;
      end else if (state_q == TRK_FALL) begin
        y_d = y_sum[9:0];
        if (y_sum > {1'b0, BOTTOM_Y}) state_d = TRK_RETIRED;
      end
    end
  end

  always_comb begin
    o_active = (state_q == TRK_FALL);
    o_y      = y_q;
    in_band  = (y_q >= PENG_Y_TOP) && (y_q <= PENG_Y_BOT);
    o_hit    = o_active && (lane_q == i_penguin_lane) && in_band && !i_hit_mask;
  end

endmodule

// File: rtl/obstacle_tracker.sv
// Coin and barrier tracks plus the lives, score, invulnerability and
// hit-hold bookkeeping; everything advances on enabled frame ticks.
module obstacle_tracker
  import obstacle_tracker_pkg::*;
#(
  parameter logic [9:0] TOP_Y           = 10'd40,
  parameter logic [9:0] BOTTOM_Y        = 10'd470,
  parameter logic [9:0] PENG_Y_TOP      = 10'd380,
  parameter logic [9:0] PENG_Y_BOT      = 10'd440,
  parameter logic [3:0] SCROLL_STEP     = 4'd4,
  parameter logic [1:0] INIT_LIVES      = 2'd3,
  parameter logic [2:0] HIT_HOLD_FRAMES = 3'd2,
  parameter logic [5:0] INVULN_FRAMES   = 6'd48
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_tick,
  input  logic       i_game_en,
  input  logic [1:0] i_release_coin,
  input  logic [1:0] i_release_barrier,
  input  logic [1:0] i_penguin_lane,
  input  logic       i_penguin_jump,
  output logic       o_coin_active,
  output logic [9:0] o_coin_y,
  output logic       o_barrier_active,
  output logic [9:0] o_barrier_y,
  output logic       o_penguin_hit,
  output logic       o_coin_hit,
  output logic [1:0] o_lives,
  output logic [7:0] o_score,
  output logic       o_zero_lives
);

  logic [1:0] lives_q, lives_d;
  logic [7:0] score_q, score_d;
  logic [5:0] inv_q, inv_d;
  logic [2:0] coin_hold_q, coin_hold_d;
  logic [2:0] bar_hold_q, bar_hold_d;
  logic       tick_en, step, bar_mask;
  logic       coin_hit_raw, bar_hit_raw, coin_hit, bar_hit;

  assign tick_en  = i_frame_tick & i_game_en;
  // With no lives left only the hold counters keep draining.
  assign step     = tick_en & (lives_q != 2'd0);
  assign bar_mask = i_penguin_jump | (inv_q != 6'd0);
  assign coin_hit = coin_hit_raw & step;
  assign bar_hit  = bar_hit_raw & step;

  object_track #(
    .TOP_Y(TOP_Y), .BOTTOM_Y(BOTTOM_Y), .PENG_Y_TOP(PENG_Y_TOP),
    .PENG_Y_BOT(PENG_Y_BOT), .SCROLL_STEP(SCROLL_STEP)
  ) u_coin_track (
    .i_clk(i_clk), .i_rst(i_rst), .i_step(step), .i_release(i_release_coin),
    .i_penguin_lane(i_penguin_lane), .i_hit_mask(1'b0),
    .o_active(o_coin_active), .o_y(o_coin_y), .o_hit(coin_hit_raw)
  );

  object_track #(
    .TOP_Y(TOP_Y), .BOTTOM_Y(BOTTOM_Y), .PENG_Y_TOP(PENG_Y_TOP),
    .PENG_Y_BOT(PENG_Y_BOT), .SCROLL_STEP(SCROLL_STEP)
  ) u_barrier_track (
    .i_clk(i_clk), .i_rst(i_rst), .i_step(step), .i_release(i_release_barrier),
    .i_penguin_lane(i_penguin_lane), .i_hit_mask(bar_mask),
    .o_active(o_barrier_active), .o_y(o_barrier_y), .o_hit(bar_hit_raw)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lives_q     <= INIT_LIVES;
      score_q     <= 8'd0;
      inv_q       <= 6'd0;
      coin_hold_q <= 3'd0;
      bar_hold_q  <= 3'd0;
    end else begin
      lives_q     <= lives_d;
      score_q     <= score_d;
      inv_q       <= inv_d;
      coin_hold_q <= coin_hold_d;
      bar_hold_q  <= bar_hold_d;
    end
  end

  always_comb begin
    lives_d     = lives_q;
    score_d     = score_q;
    inv_d       = inv_q;
    coin_hold_d = coin_hold_q;
    bar_hold_d  = bar_hold_q;
    if (step) begin
      if (bar_hit)               inv_d = INVULN_FRAMES;
      else if (inv_q != 6'd0)    inv_d = inv_q - 6'd1;
      if (bar_hit && lives_q != 2'd0)    lives_d = lives_q - 2'd1;
      if (coin_hit && score_q != 8'hff)  score_d = score_q + 8'd1;
    end
    if (tick_en) begin
      if (coin_hit)                  coin_hold_d = HIT_HOLD_FRAMES;
      else if (coin_hold_q != 3'd0)  coin_hold_d = coin_hold_q - 3'd1;
      if (bar_hit)                   bar_hold_d = HIT_HOLD_FRAMES;
      else if (bar_hold_q != 3'd0)   bar_hold_d = bar_hold_q - 3'd1;
    end
  end

  assign o_penguin_hit = (bar_hold_q != 3'd0);
  assign o_coin_hit    = (coin_hold_q != 3'd0);
  assign o_lives       = lives_q;
  assign o_score       = score_q;
  assign o_zero_lives  = (lives_q == 2'd0);

endmodule

// File: doc/obstacle_tracker.md
# obstacle_tracker

Downstream stage of the level sequencer. It turns the sequencer's coin/barrier release lanes into moving on-screen objects and detects collisions with the penguin. It returns held hit flags and a zero-lives flag to the sequencer, and keeps the lives count and coin score for the HUD. Object positions feed the sprite renderer. All updates are paced by a one-cycle frame strobe.

## Interface
Parameters:
- TOP_Y, 10'd40: y at which a newly released object spawns
- BOTTOM_Y, 10'd470: object retires once y exceeds this
- PENG_Y_TOP, 10'd380: top of the penguin collision band (inclusive)
- PENG_Y_BOT, 10'd440: bottom of the penguin collision band (inclusive)
- SCROLL_STEP, 4'd4: pixels advanced per frame tick
- INIT_LIVES, 2'd3: lives after reset
- HIT_HOLD_FRAMES, 3'd2: frame ticks a hit flag stays high
- INVULN_FRAMES, 6'd48: frame ticks after a barrier hit during which barrier hits are ignored

Ports (one clock; reset is synchronous and active-high):
- i_clk, in, 1: system clock
- i_rst, in, 1: synchronous active-high reset
- i_frame_tick, in, 1: one-cycle strobe, once per frame
- i_game_en, in, 1: game switch; 0 freezes all state
- i_release_coin, in, 2: coin lane from the sequencer (00 null, 01 left, 10 mid, 11 right)
- i_release_barrier, in, 2: barrier lane, same encoding
- i_penguin_lane, in, 2: current penguin lane (01/10/11)
- i_penguin_jump, in, 1: penguin is airborne
- o_coin_active, out, 1: coin object visible
- o_coin_y, out, 10: coin y position
- o_barrier_active, out, 1: barrier object visible
- o_barrier_y, out, 10: barrier y position
- o_penguin_hit, out, 1: held barrier-hit flag
- o_coin_hit, out, 1: held coin-hit flag
- o_lives, out, 2: remaining lives
- o_score, out, 8: coins collected
- o_zero_lives, out, 1: high when o_lives == 0

## Operation
- Reset values: both active flags 0, both y = TOP_Y, both hit flags 0, o_lives = INIT_LIVES, o_score = 0, o_zero_lives = 0, invulnerability counter 0, hold counters 0. Stored lanes are cleared to 00.
- Each track (coin, barrier) is one FSM with states IDLE, FALL, RETIRED:
  - Spawn: on a tick, if the release lane is non-null and differs from the stored lane, enter FALL with y = TOP_Y. This applies from any state, so a direct change such as 11 to 01 respawns the object.
  - FALL: each tick, y <= y + SCROLL_STEP. The sum is computed 11 bits wide. If the sum exceeds BOTTOM_Y, go to RETIRED.
  - RETIRED: object inactive; stay here until the release lane changes.
  - Release lane becomes 00: go to IDLE and clear the stored lane.
  - Hit: go to RETIRED.
- Collision test runs on the tick, using pre-update y. A hit requires the track in FALL, object lane == i_penguin_lane, and PENG_Y_TOP <= y <= PENG_Y_BOT.
  - Barrier hit is additionally masked by i_penguin_jump or invulnerability counter != 0.
  - Coin hit is not masked by jump.
- Barrier hit:
  - o_lives decrements, saturating at 0.
  - Invulnerability counter loads INVULN_FRAMES, then decrements once per tick.
  - Barrier hold counter loads HIT_HOLD_FRAMES.
- Coin hit: o_score increments, saturating at 255; coin hold counter loads HIT_HOLD_FRAMES.
- A hit flag is high while its hold counter != 0. Each hold counter decrements once per tick. A new hit reloads the counter.
- Coin and barrier hits in the same tick are both processed.
- Once o_zero_lives = 1, everything freezes until reset (tracks, score, counters; hold counters still drain).
- i_game_en = 0: no state changes at all, ticks included.

## Timing
- All state updates happen on the i_clk edge where i_frame_tick = 1 (ticks with i_game_en = 1 only). Outputs are registered: they change one cycle after the tick edge.
- Hit flag stays high exactly HIT_HOLD_FRAMES ticks. This guarantees the sequencer samples it at least once.
- o_zero_lives rises in the same cycle that o_lives reaches 0.
- i_rst wins over i_frame_tick in the same cycle. Reset mid-fall returns all tracks to IDLE.

## Structure
- Shared package: lane encoding constants (NULL/LEFT/MID/RIGHT) and the track state enum, reused by the sequencer and the renderer.
- One sub-module, object_track, instantiated twice (coin, barrier). It holds the FSM, y, stored lane and collision compare. The top level owns lives, score, invulnerability and hold counters.

## Test plan
- Coin lane 10 with penguin lane 10: coin spawns y = 40 and reaches 380 after 85 ticks → o_coin_hit high 2 ticks, o_score = 1, o_coin_active = 0.
- Barrier lane 11 with penguin lane 01: barrier falls to 472 > 470 → retired, no hit, o_lives = 3.
- Barrier hit with jump high across the whole band: no hit. Barrier hit at lives 3 → o_lives = 2; a second barrier spawned immediately is ignored inside 48 ticks.
- Three spaced barrier hits → o_lives = 0, o_zero_lives = 1. A later coin in the penguin lane produces no score change.
- Coin lane changes 11 to 01 mid-fall → respawn at y = 40 in lane 01. i_game_en = 0 for 10 ticks → y unchanged.
- Reset while both tracks are falling and a hit flag is high → all outputs at reset values next cycle.
